data_sram_bridge: RTL and testbench

- Sits directly downstream of the pipeline's memory-access stage, between the datapath and the data-side sram-like bus.
- Converts one held load/store request per instruction into a req/addr_ok/data_ok transaction.
- Stalls the pipeline until the transaction completes.
- Performs store byte-lane replication and load byte/half extraction with sign/zero extension.

---
 rtl/data_sram_bridge_if.sv | 44 ++++
 rtl/data_sram_bridge.sv | 160 ++++++++++++++++
 tb/tb_data_sram_bridge.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// data_sram_bridge_if : memory-stage request side and sram-like data bus side
// Rev 1.0
// ============================================================================
interface data_sram_bridge_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic        cpu_sign;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_flush;
  logic        mem_allowin;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        adel;
  logic        ades;

  // master: the bridge (bus master on the sram-like side)
  modport master (
    input  cpu_req, cpu_wr, cpu_size, cpu_sign, cpu_addr, cpu_wdata,
           cpu_flush, mem_allowin, data_rdata, data_addr_ok, data_data_ok,
    output cpu_rdata, cpu_stall, data_req, data_wr, data_size, data_addr,
           data_wdata, adel, ades
  );

  // slave: pipeline plus memory system seen from the outside
  modport slave (
    output cpu_req, cpu_wr, cpu_size, cpu_sign, cpu_addr, cpu_wdata,
           cpu_flush, mem_allowin, data_rdata, data_addr_ok, data_data_ok,
    input  cpu_rdata, cpu_stall, data_req, data_wr, data_size, data_addr,
           data_wdata, adel, ades
  );
endinterface
`default_nettype wire

// File: rtl/data_sram_bridge.sv
`default_nettype none
// ============================================================================
// data_sram_bridge : one held load/store -> req/addr_ok/data_ok transaction,
// with store lane replication and load extraction. MISALIGN_CHK_EN adds adel/ades.
// Rev 1.0
// ============================================================================
module data_sram_bridge (
  input  logic               clk,
  input  logic               rstn,
  data_sram_bridge_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;

  logic        latch_en;
  logic        capture;
  logic        misalign;
  logic [1:0]  size_norm;
  logic [31:0] wdata_rep;
  logic [15:0] rsh;
  logic [31:0] load_ext;

  assign size_norm = (bus.cpu_size == 2'd3) ? 2'd2 : bus.cpu_size;

  always_comb begin
    wdata_rep = bus.cpu_wdata;
    case (size_norm)
      2'd0:    wdata_rep = {4{bus.cpu_wdata[7:0]}};
      2'd1:    wdata_rep = {2{bus.cpu_wdata[15:0]}};
      default: wdata_rep = bus.cpu_wdata;
    endcase
  end

  // only the low half of the lane-shifted read data is ever needed
  assign rsh = 16'(bus.data_rdata >> {addr_q[1:0], 3'b000});

  always_comb begin
    load_ext = bus.data_rdata;
    case (size_q)
      2'd0:    load_ext = {{24{sign_q & rsh[7]}}, rsh[7:0]};
      2'd1:    load_ext = {{16{sign_q & rsh[15]}}, rsh[15:0]};
      default: load_ext = bus.data_rdata;
    endcase
  end

`ifdef MISALIGN_CHK_EN
  logic err_q;

  assign misalign = ((size_norm == 2'd1) && bus.cpu_addr[0]) ||
                    ((size_norm == 2'd2) && (bus.cpu_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (latch_en) begin
      err_q <= misalign;
    end
  end

  assign bus.adel = (state_q == S_DONE) && err_q && !wr_q;
  assign bus.ades = (state_q == S_DONE) && err_q && wr_q;
`else
  assign misalign = 1'b0;
  assign bus.adel = 1'b0;
  assign bus.ades = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req && !bus.cpu_flush) begin
          latch_en = 1'b1;
          state_d  = misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.data_addr_ok) begin
          state_d = bus.cpu_flush ? S_DRAIN : S_WAIT;
        end else if (bus.cpu_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // a flush landing with data_ok completes the bus side; drop the data
        if (bus.data_data_ok) begin
          if (bus.cpu_flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            capture = !wr_q;
          end
        end else if (bus.cpu_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (bus.mem_allowin || bus.cpu_flush) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.data_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_d = capture ? load_ext : rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (latch_en) begin
        wr_q    <= bus.cpu_wr;
        size_q  <= size_norm;
        sign_q  <= bus.cpu_sign;
        addr_q  <= bus.cpu_addr;
        wdata_q <= wdata_rep;
      end
    end
  end

  assign bus.data_req   = (state_q == S_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_stall  = bus.cpu_req && !bus.cpu_flush && (state_q != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_data_sram_bridge.sv
`default_nettype none
// ============================================================================
// tb_data_sram_bridge : directed and random transactions against a
// transaction-level reference model of data_sram_bridge.
// Rev 1.0
// ============================================================================
module tb_data_sram_bridge;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  logic [31:0] last_rdata;

  data_sram_bridge_if b ();

  data_sram_bridge dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sign,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] mask;
    int          bits;
    if (size >= 2'd2) return rd;
    bits = (size == 2'd0) ? 8 : 16;
    mask = (32'd1 << bits) - 32'd1;
    v    = (rd >> (8 * int'(addr[1:0]))) & mask;
    if (sign && ((v >> (bits - 1)) & 32'd1) != 32'd0) v = v | ~mask;
    return v;
  endfunction

  // One complete request: bus responder inline, then DONE held for 'hold' cycles.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int adly, input int ddly,
                         input int hold);
    int          req_cnt, stall_cnt, wcnt;
    bit          accepted, done;
    logic [1:0]  esize;
    logic [31:0] exp_rd;
    esize     = (size == 2'd3) ? 2'd2 : size;
    exp_rd    = wr ? last_rdata : m_load(esize, sign, addr, rdata);
    req_cnt   = 0;
    stall_cnt = 0;
    wcnt      = 0;
    accepted  = 0;
    done      = 0;
    @(negedge clk);
    b.cpu_req     = 1'b1;
    b.cpu_wr      = wr;
    b.cpu_size    = size;
    b.cpu_sign    = sign;
    b.cpu_addr    = addr;
    b.cpu_wdata   = wdata;
    b.cpu_flush   = 1'b0;
    b.mem_allowin = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c != 0) @(negedge clk);
      b.data_addr_ok = 1'b0;
      b.data_data_ok = 1'b0;
      b.data_rdata   = $urandom;
      if (accepted) begin
        wcnt++;
        if (wcnt == ddly) begin
          b.data_data_ok = 1'b1;
          b.data_rdata   = rdata;
        end
      end
      if (b.data_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check("bus_wr",   b.data_wr,   wr);
          check("bus_size", b.data_size, esize);
          check("bus_addr", b.data_addr, addr);
          if (wr) check("bus_wdata", b.data_wdata, m_wdata(esize, wdata));
        end
        if (req_cnt == adly + 1) begin
          b.data_addr_ok = 1'b1;
          accepted       = 1;
        end
      end
      #1;
      if (b.cpu_stall) stall_cnt++;
      else done = 1;
    end
    b.data_addr_ok = 1'b0;
    b.data_data_ok = 1'b0;
    check("txn_done",    done,      1);
    check("stall_cycles", stall_cnt, adly + ddly + 2);
    check("req_cycles",  req_cnt,   adly + 1);
    check("rdata_done",  b.cpu_rdata, exp_rd);
    check("adel_norm",   b.adel, 1'b0);
    check("ades_norm",   b.ades, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("hold_stall", b.cpu_stall, 1'b0);
      check("hold_req",   b.data_req,  1'b0);
      check("hold_rdata", b.cpu_rdata, exp_rd);
    end
    @(negedge clk);
    b.mem_allowin = 1'b1;
    #1;
    @(negedge clk);
    b.cpu_req     = 1'b0;
    b.mem_allowin = 1'b0;
    #1;
    check("no_reissue", b.data_req,  1'b0);
    check("post_stall", b.cpu_stall, 1'b0);
    last_rdata = exp_rd;
  endtask

  initial begin
    logic [1:0]  rsize;
    logic [31:0] raddr;
    total          = 0;
    bad            = 0;
    last_rdata     = 32'd0;
    rstn           = 1'b0;
    b.cpu_req      = 1'b0;
    b.cpu_wr       = 1'b0;
    b.cpu_size     = 2'd0;
    b.cpu_sign     = 1'b0;
    b.cpu_addr     = 32'd0;
    b.cpu_wdata    = 32'd0;
    b.cpu_flush    = 1'b0;
    b.mem_allowin  = 1'b0;
    b.data_rdata   = 32'd0;
    b.data_addr_ok = 1'b0;
    b.data_data_ok = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_rdata", b.cpu_rdata,  32'd0);
    check("rst_stall", b.cpu_stall,  1'b0);
    check("rst_req",   b.data_req,   1'b0);
    check("rst_wr",    b.data_wr,    1'b0);
    check("rst_size",  b.data_size,  2'd0);
    check("rst_addr",  b.data_addr,  32'd0);
    check("rst_wdata", b.data_wdata, 32'd0);
    check("rst_adel",  b.adel,       1'b0);
    check("rst_ades",  b.ades,       1'b0);
    rstn = 1'b1;

    // word load, signed/unsigned byte loads, half store, backpressure
    run_txn(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'd0, 32'hDEAD_BEEF, 0, 2, 0);
    check("word_load", b.cpu_rdata, 32'hDEAD_BEEF);
    run_txn(1'b0, 2'd0, 1'b1, 32'h1000_0013, 32'd0, 32'h8012_3456, 0, 1, 0);
    check("byte_sx", b.cpu_rdata, 32'hFFFF_FF80);
    run_txn(1'b0, 2'd0, 1'b0, 32'h1000_0013, 32'd0, 32'h8012_3456, 0, 1, 0);
    check("byte_zx", b.cpu_rdata, 32'h0000_0080);
    run_txn(1'b1, 2'd1, 1'b0, 32'h1000_0022, 32'h1234_ABCD, 32'd0, 1, 1, 1);
    check("store_keeps_rdata", b.cpu_rdata, 32'h0000_0080);
    run_txn(1'b0, 2'd1, 1'b1, 32'h1000_0032, 32'd0, 32'hC001_7FFF, 5, 1, 3);
    run_txn(1'b1, 2'd3, 1'b0, 32'h1000_0040, 32'hCAFE_F00D, 32'd0, 0, 1, 0);

    // flush in WAIT: drain the pending data_ok, keep cpu_rdata
    @(negedge clk);
    b.cpu_req  = 1'b1;
    b.cpu_wr   = 1'b0;
    b.cpu_size = 2'd2;
    b.cpu_addr = 32'h2000_0000;
    #1;
    check("fw_idle_stall", b.cpu_stall, 1'b1);
    @(negedge clk);
    b.data_addr_ok = 1'b1;
    #1;
    check("fw_req", b.data_req, 1'b1);
    @(negedge clk);
    b.data_addr_ok = 1'b0;
    b.cpu_flush    = 1'b1;
    #1;
    check("fw_wait_req", b.data_req, 1'b0);
    @(negedge clk);
    b.cpu_flush = 1'b0;
    b.cpu_req   = 1'b0;
    #1;
    check("fw_drain_req", b.data_req, 1'b0);
    @(negedge clk);
    b.data_data_ok = 1'b1;
    b.data_rdata   = 32'h5555_5555;
    @(negedge clk);
    b.data_data_ok = 1'b0;
    #1;
    check("fw_rdata_kept", b.cpu_rdata, last_rdata);
    check("fw_idle_req",   b.data_req,  1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h2000_0008, 32'd0, 32'h0BAD_CAFE, 0, 1, 0);

    // flush in REQ before addr_ok: no transaction
    @(negedge clk);
    b.cpu_req  = 1'b1;
    b.cpu_wr   = 1'b1;
    b.cpu_size = 2'd2;
    b.cpu_addr = 32'h3000_0000;
    @(negedge clk);
    b.cpu_flush = 1'b1;
    #1;
    check("fr_req", b.data_req, 1'b1);
    @(negedge clk);
    b.cpu_flush = 1'b0;
    b.cpu_req   = 1'b0;
    #1;
    check("fr_dropped", b.data_req, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h3000_0001, 32'd0, 32'h0000_A500, 2, 2, 0);

    // asynchronous reset mid-REQ
    @(negedge clk);
    b.cpu_req  = 1'b1;
    b.cpu_wr   = 1'b0;
    b.cpu_size = 2'd2;
    b.cpu_addr = 32'h4000_0000;
    @(negedge clk);
    #1;
    check("ar_req_before", b.data_req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("ar_req_async", b.data_req,  1'b0);
    check("ar_rdata",     b.cpu_rdata, 32'd0);
    b.cpu_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    last_rdata = 32'd0;

`ifdef MISALIGN_CHK_EN
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      b.cpu_req  = 1'b1;
      b.cpu_wr   = w[0];
      b.cpu_size = 2'd2;
      b.cpu_addr = 32'h5000_0001;
      #1;
      check("mis_idle_stall", b.cpu_stall, 1'b1);
      @(negedge clk);
      b.mem_allowin = 1'b1;
      #1;
      check("mis_req",   b.data_req,  1'b0);
      check("mis_stall", b.cpu_stall, 1'b0);
      check("mis_adel",  b.adel,      w == 0);
      check("mis_ades",  b.ades,      w == 1);
      check("mis_rdata", b.cpu_rdata, last_rdata);
      @(negedge clk);
      b.cpu_req     = 1'b0;
      b.mem_allowin = 1'b0;
      #1;
      check("mis_adel_off", b.adel, 1'b0);
      check("mis_ades_off", b.ades, 1'b0);
    end
`else
    run_txn(1'b0, 2'd2, 1'b0, 32'h5000_0001, 32'd0, 32'h1357_9BDF, 0, 1, 0);
    check("mis_passthru", b.cpu_rdata, 32'h1357_9BDF);
`endif

    // random aligned transactions
    for (int n = 0; n < 30; n++) begin
      rsize = 2'($urandom_range(0, 3));
      raddr = $urandom & 32'hFFFF_FFFC;
      if (rsize == 2'd0) raddr = raddr | 32'($urandom_range(0, 3));
      if (rsize == 2'd1) raddr = raddr | 32'(2 * $urandom_range(0, 1));
      run_txn(1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)), raddr,
              $urandom, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
